// File: rtl/axil_mp_ram_pkg.sv
// axil_mp_ram_pkg: shared response codes and width helper for the multi-port AXI-Lite RAM.
package axil_mp_ram_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/axil_rr_arbiter.sv
// axil_rr_arbiter: round-robin grant of one requester per cycle, pointer advances past each winner.
module axil_rr_arbiter import axil_mp_ram_pkg::*; #(
  parameter int PORTS = 4,
  localparam int IW = PORTS > 1 ? clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] req_i,
  input  logic             advance_i,
  output logic [PORTS-1:0] grant_o,
  output logic [IW-1:0]    grant_idx_o,
  output logic             valid_o
);
  logic [IW-1:0] ptr_q, ptr_d;
  // Scan from the far end so the last hit, i.e. the first port at/after the pointer, wins.
  always_comb begin
    grant_idx_o = '0;
    valid_o = 1'b0;
    for (int i = PORTS - 1; i >= 0; i--)
      if (req_i[(int'(ptr_q) + i) % PORTS]) begin
        grant_idx_o = IW'((int'(ptr_q) + i) % PORTS);
        valid_o = 1'b1;
      end
    grant_o = valid_o ? PORTS'(1) << grant_idx_o : '0;
    ptr_d = (grant_idx_o == IW'(PORTS - 1)) ? '0 : grant_idx_o + 1'b1;
  end
  always_ff @(posedge clk)
    if (rst) ptr_q <= '0;
    else if (advance_i && valid_o) ptr_q <= ptr_d;
endmodule

// File: rtl/axil_mp_ram.sv
// axil_mp_ram: NUM_PORTS AXI-Lite slaves sharing one word-wide RAM, one access per cycle.
module axil_mp_ram import axil_mp_ram_pkg::*; #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int PIPELINE_OUTPUT = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_axil_awaddr,
  input  logic [NUM_PORTS*3-1:0]           s_axil_awprot,
  input  logic [NUM_PORTS-1:0]             s_axil_awvalid,
  output logic [NUM_PORTS-1:0]             s_axil_awready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axil_wdata,
  input  logic [NUM_PORTS*STRB_WIDTH-1:0]  s_axil_wstrb,
  input  logic [NUM_PORTS-1:0]             s_axil_wvalid,
  output logic [NUM_PORTS-1:0]             s_axil_wready,
  output logic [NUM_PORTS*2-1:0]           s_axil_bresp,
  output logic [NUM_PORTS-1:0]             s_axil_bvalid,
  input  logic [NUM_PORTS-1:0]             s_axil_bready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_axil_araddr,
  input  logic [NUM_PORTS*3-1:0]           s_axil_arprot,
  input  logic [NUM_PORTS-1:0]             s_axil_arvalid,
  output logic [NUM_PORTS-1:0]             s_axil_arready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axil_rdata,
  output logic [NUM_PORTS*2-1:0]           s_axil_rresp,
  output logic [NUM_PORTS-1:0]             s_axil_rvalid,
  input  logic [NUM_PORTS-1:0]             s_axil_rready
);
  localparam int WORD_LSB = clog2(STRB_WIDTH);
  localparam int IW = NUM_PORTS > 1 ? clog2(NUM_PORTS) : 1;
  localparam int DEPTH = 2 ** (ADDR_WIDTH - WORD_LSB);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [NUM_PORTS-1:0] bvalid_q, rvalid_q, tog_q;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_q;
  logic s1_vld_q;
  logic [IW-1:0] s1_idx_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [NUM_PORTS-1:0] busy, wreq, rreq, req, gnt;
  logic [IW-1:0] gidx, dlv_idx;
  logic gvalid, do_write, do_read, dlv_vld;
  logic [ADDR_WIDTH-1:0] awaddr_sel, araddr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel, rd_word, dlv_data;
  logic [STRB_WIDTH-1:0] wstrb_sel;
  logic unused_ok;
  // A port with any response outstanding (including one still in the output stage) may not request.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      busy[p] = bvalid_q[p] | rvalid_q[p] | ((PIPELINE_OUTPUT != 0) && s1_vld_q && (s1_idx_q == IW'(p)));
      wreq[p] = s_axil_awvalid[p] & s_axil_wvalid[p] & ~busy[p];
      rreq[p] = s_axil_arvalid[p] & ~busy[p];
    end
    req = rst ? '0 : (wreq | rreq);
  end
  axil_rr_arbiter #(.PORTS(NUM_PORTS)) u_arb (
    .clk(clk),
    .rst(rst),
    .req_i(req),
    .advance_i(gvalid),
    .grant_o(gnt),
    .grant_idx_o(gidx),
    .valid_o(gvalid)
  );
  assign do_write = gvalid & wreq[gidx] & (~rreq[gidx] | ~tog_q[gidx]);
  assign do_read = gvalid & rreq[gidx] & ~do_write;
  assign s_axil_awready = do_write ? gnt : '0;
  assign s_axil_wready = do_write ? gnt : '0;
  assign s_axil_arready = do_read ? gnt : '0;
  assign s_axil_bvalid = bvalid_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata = rdata_q;
  assign s_axil_bresp = {NUM_PORTS{RESP_OKAY}};
  assign s_axil_rresp = {NUM_PORTS{RESP_OKAY}};
  assign awaddr_sel = s_axil_awaddr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
  assign araddr_sel = s_axil_araddr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
  assign wdata_sel = s_axil_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
  assign wstrb_sel = s_axil_wstrb[gidx*STRB_WIDTH +: STRB_WIDTH];
  assign rd_word = mem[araddr_sel[ADDR_WIDTH-1:WORD_LSB]];
  assign dlv_vld = (PIPELINE_OUTPUT != 0) ? s1_vld_q : do_read;
  assign dlv_idx = (PIPELINE_OUTPUT != 0) ? s1_idx_q : gidx;
  assign dlv_data = (PIPELINE_OUTPUT != 0) ? s1_data_q : rd_word;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, awaddr_sel[WORD_LSB-1:0], araddr_sel[WORD_LSB-1:0], RESP_SLVERR};
  always_ff @(posedge clk)
    if (do_write)
      for (int i = 0; i < STRB_WIDTH; i++)
        if (wstrb_sel[i]) mem[awaddr_sel[ADDR_WIDTH-1:WORD_LSB]][i*8 +: 8] <= wdata_sel[i*8 +: 8];
  always_ff @(posedge clk)
    if (rst) begin
      bvalid_q <= '0;
      rvalid_q <= '0;
      tog_q <= '0;
      rdata_q <= '0;
      s1_vld_q <= 1'b0;
      s1_idx_q <= '0;
      s1_data_q <= '0;
    end else begin
      bvalid_q <= bvalid_q & ~s_axil_bready;
      if (do_write) bvalid_q[gidx] <= 1'b1;
      rvalid_q <= rvalid_q & ~s_axil_rready;
      if (dlv_vld) begin
        rvalid_q[dlv_idx] <= 1'b1;
        rdata_q[dlv_idx*DATA_WIDTH +: DATA_WIDTH] <= dlv_data;
      end
      if (gvalid) tog_q[gidx] <= ~tog_q[gidx];
      s1_vld_q <= do_read;
      s1_idx_q <= gidx;
      s1_data_q <= rd_word;
    end
endmodule

// File: tb/tb_axil_mp_ram.sv
// tb_axil_mp_ram: directed tests for the 4-port AXI-Lite RAM, direct and pipelined read variants.
module tb_axil_mp_ram;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [35:0] awaddr = '0, araddr = '0, p_awaddr = '0, p_araddr = '0;
  logic [11:0] awprot = '0, arprot = '0, p_awprot = '0, p_arprot = '0;
  logic [127:0] wdata = '0, rdata, p_wdata = '0, p_rdata;
  logic [15:0] wstrb = '0, p_wstrb = '0;
  logic [7:0] bresp, rresp, p_bresp, p_rresp;
  logic [3:0] awvalid = '0, awready, wvalid = '0, wready, bvalid, bready = 4'hF;
  logic [3:0] arvalid = '0, arready, rvalid, rready = 4'hF;
  logic [3:0] p_awvalid = '0, p_awready, p_wvalid = '0, p_wready, p_bvalid, p_bready = 4'hF;
  logic [3:0] p_arvalid = '0, p_arready, p_rvalid, p_rready = 4'hF;
  axil_mp_ram #(.NUM_PORTS(4), .ADDR_WIDTH(9), .DATA_WIDTH(32), .PIPELINE_OUTPUT(0)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready)
  );
  axil_mp_ram #(.NUM_PORTS(4), .ADDR_WIDTH(9), .DATA_WIDTH(32), .PIPELINE_OUTPUT(1)) dut_p (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(p_awaddr), .s_axil_awprot(p_awprot), .s_axil_awvalid(p_awvalid), .s_axil_awready(p_awready),
    .s_axil_wdata(p_wdata), .s_axil_wstrb(p_wstrb), .s_axil_wvalid(p_wvalid), .s_axil_wready(p_wready),
    .s_axil_bresp(p_bresp), .s_axil_bvalid(p_bvalid), .s_axil_bready(p_bready),
    .s_axil_araddr(p_araddr), .s_axil_arprot(p_arprot), .s_axil_arvalid(p_arvalid), .s_axil_arready(p_arready),
    .s_axil_rdata(p_rdata), .s_axil_rresp(p_rresp), .s_axil_rvalid(p_rvalid), .s_axil_rready(p_rready)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int p, input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    awaddr[p*9 +: 9] = a;
    wdata[p*32 +: 32] = d;
    wstrb[p*4 +: 4] = s;
    awvalid[p] = 1'b1;
    wvalid[p] = 1'b1;
    #1;
    while (!awready[p] && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout port=%0d awready never seen, required within 50 cycles", p);
    end
    tick();
    awvalid[p] = 1'b0;
    wvalid[p] = 1'b0;
  endtask
  task automatic rd(input int p, input logic [8:0] a);
    int n;
    n = 0;
    araddr[p*9 +: 9] = a;
    arvalid[p] = 1'b1;
    #1;
    while (!arready[p] && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL rd_timeout port=%0d arready never seen, required within 50 cycles", p);
    end
    tick();
    arvalid[p] = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    arvalid[0] = 1'b1;
    awvalid[1] = 1'b1;
    wvalid[1] = 1'b1;
    tick();
    tick();
    checks++;
    if ({arready, awready, wready} !== 12'h000) begin
      errors++;
      $display("FAIL ready_in_reset got ar=%b aw=%b w=%b required all 0", arready, awready, wready);
    end
    checks++;
    if ({bvalid, rvalid} !== 8'h00) begin
      errors++;
      $display("FAIL valid_in_reset got b=%b r=%b required 0", bvalid, rvalid);
    end
    checks++;
    if (rdata !== '0 || bresp !== '0 || rresp !== '0) begin
      errors++;
      $display("FAIL data_in_reset got rdata=%h bresp=%h rresp=%h required 0", rdata, bresp, rresp);
    end
    checks++;
    if (p_rvalid !== 4'h0 || p_rdata !== '0) begin
      errors++;
      $display("FAIL pipe_in_reset got rvalid=%b rdata=%h required 0", p_rvalid, p_rdata);
    end
    arvalid = '0;
    awvalid = '0;
    wvalid = '0;
    rst = 1'b0;
    tick();
  endtask
  task automatic test_single_write();
    bready = 4'h0;
    awaddr[8:0] = 9'h010;
    wdata[31:0] = 32'hDEADBEEF;
    wstrb[3:0] = 4'hF;
    awvalid[0] = 1'b1;
    wvalid[0] = 1'b1;
    #1;
    checks++;
    if (awready !== 4'b0001 || wready !== 4'b0001) begin
      errors++;
      $display("FAIL aw_grant got aw=%b w=%b required 0001", awready, wready);
    end
    tick();
    awvalid = '0;
    wvalid = '0;
    checks++;
    if (bvalid !== 4'b0001 || bresp !== 8'h00) begin
      errors++;
      $display("FAIL bvalid_rise got bvalid=%b bresp=%h required 0001/00", bvalid, bresp);
    end
    tick();
    checks++;
    if (bvalid !== 4'b0001) begin
      errors++;
      $display("FAIL bvalid_hold got %b required 0001", bvalid);
    end
    bready = 4'hF;
    tick();
    checks++;
    if (bvalid !== 4'b0000) begin
      errors++;
      $display("FAIL bvalid_clear got %b required 0000", bvalid);
    end
    araddr[17:9] = 9'h010;
    arvalid[1] = 1'b1;
    #1;
    checks++;
    if (arready !== 4'b0010) begin
      errors++;
      $display("FAIL ar_grant got %b required 0010", arready);
    end
    tick();
    arvalid = '0;
    checks++;
    if (rvalid !== 4'b0010 || rdata[63:32] !== 32'hDEADBEEF || rresp !== 8'h00) begin
      errors++;
      $display("FAIL read_back got rvalid=%b rdata=%h required 0010/deadbeef", rvalid, rdata[63:32]);
    end
    tick();
    checks++;
    if (rvalid !== 4'b0000) begin
      errors++;
      $display("FAIL rvalid_clear got %b required 0000", rvalid);
    end
  endtask
  task automatic test_strobes();
    wr(2, 9'h020, 32'h11223344, 4'hF);
    wr(2, 9'h022, 32'hAABBCCDD, 4'b0101);
    rd(0, 9'h020);
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[31:0] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strobe_merge got rvalid=%b rdata=%h required 1/11bb33dd", rvalid[0], rdata[31:0]);
    end
    tick();
  endtask
  task automatic test_contention();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      arvalid = 4'hF;
      for (int k = 0; k < 4; k++) begin
        #1;
        checks++;
        if (arready !== 4'(1 << k)) begin
          errors++;
          $display("FAIL rr_order round=%0d step=%0d got %b required %b", r, k, arready, 4'(1 << k));
        end
        tick();
        arvalid[k] = 1'b0;
      end
    end
  endtask
  task automatic test_collision();
    awaddr[8:0] = 9'h050;
    wdata[31:0] = 32'h5A5A0001;
    wstrb[3:0] = 4'hF;
    awvalid[0] = 1'b1;
    wvalid[0] = 1'b1;
    araddr[17:9] = 9'h050;
    arvalid[1] = 1'b1;
    #1;
    checks++;
    if (awready !== 4'b0001 || arready !== 4'b0000) begin
      errors++;
      $display("FAIL collide_first got aw=%b ar=%b required 0001/0000", awready, arready);
    end
    tick();
    awvalid = '0;
    wvalid = '0;
    #1;
    checks++;
    if (arready !== 4'b0010) begin
      errors++;
      $display("FAIL collide_second got ar=%b required 0010", arready);
    end
    tick();
    arvalid = '0;
    checks++;
    if (rdata[63:32] !== 32'h5A5A0001) begin
      errors++;
      $display("FAIL read_after_write got %h required 5a5a0001", rdata[63:32]);
    end
    tick();
  endtask
  task automatic test_backpressure();
    logic [3:0] seen;
    seen = '0;
    rready[2] = 1'b0;
    rd(2, 9'h020);
    arvalid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (rvalid[2] !== 1'b1 || rdata[95:64] !== 32'h11BB33DD || arready[2] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got rvalid=%b rdata=%h ar=%b required 1/11bb33dd/0", c, rvalid[2], rdata[95:64], arready[2]);
      end
      seen |= arready;
      tick();
    end
    checks++;
    if (seen !== 4'b1011) begin
      errors++;
      $display("FAIL bp_others got grants %b required 1011", seen);
    end
    rready[2] = 1'b1;
    tick();
    arvalid = '0;
    checks++;
    if (rvalid[2] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got %b required 0", rvalid[2]);
    end
    tick();
    tick();
  endtask
  task automatic test_alternate();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    awaddr[17:9] = 9'h060;
    wdata[63:32] = 32'h600D0001;
    wstrb[7:4] = 4'hF;
    araddr[17:9] = 9'h060;
    awvalid[1] = 1'b1;
    wvalid[1] = 1'b1;
    arvalid[1] = 1'b1;
    #1;
    checks++;
    if (awready !== 4'b0010 || arready !== 4'b0000) begin
      errors++;
      $display("FAIL alt_w1 got aw=%b ar=%b required 0010/0000", awready, arready);
    end
    tick();
    checks++;
    if (awready !== 4'b0000 || arready !== 4'b0000 || bvalid !== 4'b0010) begin
      errors++;
      $display("FAIL alt_gap got aw=%b ar=%b b=%b required 0000/0000/0010", awready, arready, bvalid);
    end
    tick();
    checks++;
    if (arready !== 4'b0010 || awready !== 4'b0000) begin
      errors++;
      $display("FAIL alt_r got aw=%b ar=%b required 0000/0010", awready, arready);
    end
    tick();
    checks++;
    if (rvalid !== 4'b0010 || rdata[63:32] !== 32'h600D0001) begin
      errors++;
      $display("FAIL alt_rdata got rvalid=%b rdata=%h required 0010/600d0001", rvalid, rdata[63:32]);
    end
    tick();
    checks++;
    if (awready !== 4'b0010 || arready !== 4'b0000) begin
      errors++;
      $display("FAIL alt_w2 got aw=%b ar=%b required 0010/0000", awready, arready);
    end
    tick();
    awvalid = '0;
    wvalid = '0;
    arvalid = '0;
    tick();
    tick();
  endtask
  task automatic test_pipeline();
    p_awaddr[8:0] = 9'h070;
    p_wdata[31:0] = 32'hFEEDF00D;
    p_wstrb[3:0] = 4'hF;
    p_awvalid[0] = 1'b1;
    p_wvalid[0] = 1'b1;
    #1;
    checks++;
    if (p_awready !== 4'b0001) begin
      errors++;
      $display("FAIL pipe_aw got %b required 0001", p_awready);
    end
    tick();
    p_awvalid = '0;
    p_wvalid = '0;
    tick();
    p_araddr[26:18] = 9'h070;
    p_arvalid[2] = 1'b1;
    #1;
    checks++;
    if (p_arready !== 4'b0100) begin
      errors++;
      $display("FAIL pipe_ar got %b required 0100", p_arready);
    end
    tick();
    checks++;
    if (p_rvalid !== 4'b0000 || p_arready !== 4'b0000) begin
      errors++;
      $display("FAIL pipe_lat1 got rvalid=%b ar=%b required 0000/0000", p_rvalid, p_arready);
    end
    tick();
    p_arvalid = '0;
    checks++;
    if (p_rvalid !== 4'b0100 || p_rdata[95:64] !== 32'hFEEDF00D) begin
      errors++;
      $display("FAIL pipe_lat2 got rvalid=%b rdata=%h required 0100/feedf00d", p_rvalid, p_rdata[95:64]);
    end
    tick();
    checks++;
    if (p_rvalid !== 4'b0000) begin
      errors++;
      $display("FAIL pipe_clear got %b required 0000", p_rvalid);
    end
  endtask
  task automatic test_reset_in_flight();
    bready[3] = 1'b0;
    wr(3, 9'h080, 32'hCAFE0003, 4'hF);
    checks++;
    if (bvalid[3] !== 1'b1) begin
      errors++;
      $display("FAIL rif_bvalid got %b required 1", bvalid[3]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bvalid !== 4'h0 || rdata !== '0) begin
      errors++;
      $display("FAIL rif_cleared got bvalid=%b rdata=%h required 0", bvalid, rdata);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bvalid !== 4'h0) begin
        errors++;
        $display("FAIL rif_no_resp cyc=%0d got %b required 0000", c, bvalid);
      end
    end
    bready = 4'hF;
    rd(0, 9'h080);
    checks++;
    if (rdata[31:0] !== 32'hCAFE0003) begin
      errors++;
      $display("FAIL rif_mem_kept got %h required cafe0003", rdata[31:0]);
    end
    tick();
    rd(1, 9'h010);
    checks++;
    if (rdata[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rif_old_mem got %h required deadbeef", rdata[63:32]);
    end
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single_write();
    test_strobes();
    test_contention();
    test_collision();
    test_backpressure();
    test_alternate();
    test_pipeline();
    test_reset_in_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_mp_ram.md
Name: axil_mp_ram

Overview:
- Parametrised N-port AXI-Lite RAM. Generalises the dual-port AXI-Lite RAM wrapper to NUM_PORTS independent slave ports sharing one word-wide memory array.
- Serves at most one memory access per cycle and uses a round-robin arbiter for fairness.
- Sits behind interconnect or width adapters as a shared scratchpad, e.g. for coefficient and weight tables read by multiple compute engines.

Parameters:
- NUM_PORTS, 4, number of AXI-Lite slave ports (1..8).
- ADDR_WIDTH, 9, byte address width per port.
- DATA_WIDTH, 32, data width (16, 32 or 64).
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width.
- PIPELINE_OUTPUT, 0, when 1 adds one register stage on read data.
- WORD_LSB, $clog2(STRB_WIDTH), derived localparam; number of byte-offset address bits dropped.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axil_awaddr  in  NUM_PORTS*ADDR_WIDTH  write address; port p occupies slice p
- s_axil_awprot  in  NUM_PORTS*3  ignored
- s_axil_awvalid / s_axil_awready  in/out  NUM_PORTS  AW handshake
- s_axil_wdata  in  NUM_PORTS*DATA_WIDTH  write data
- s_axil_wstrb  in  NUM_PORTS*STRB_WIDTH  byte enables
- s_axil_wvalid / s_axil_wready  in/out  NUM_PORTS  W handshake
- s_axil_bresp  out  NUM_PORTS*2  always 2'b00
- s_axil_bvalid / s_axil_bready  out/in  NUM_PORTS  B handshake
- s_axil_araddr  in  NUM_PORTS*ADDR_WIDTH  read address
- s_axil_arprot  in  NUM_PORTS*3  ignored
- s_axil_arvalid / s_axil_arready  in/out  NUM_PORTS  AR handshake
- s_axil_rdata  out  NUM_PORTS*DATA_WIDTH  read data
- s_axil_rresp  out  NUM_PORTS*2  always 2'b00
- s_axil_rvalid / s_axil_rready  out/in  NUM_PORTS  R handshake

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All bvalid, rvalid, awready, wready and arready are 0. All rdata are 0. All bresp and rresp are 0.
  - Round-robin pointer resets to 0. Per-port write/read toggle resets to "write first".
  - Memory contents are not reset.
  - Any transaction in flight is dropped; a response pending at reset is never issued.
- Port request rules:
  - Write request: awvalid AND wvalid AND no B or R pending on that port.
  - Read request: arvalid AND no B or R pending on that port.
  - Each port has at most one outstanding transaction.
- Arbitration (combinational, each cycle):
  - Among requesting ports, grant the first at or after the pointer, wrapping modulo NUM_PORTS.
  - After a grant, pointer <= grant+1, wrapping to 0 after NUM_PORTS-1.
  - If the granted port has both a write and a read request, its toggle selects which one is served; the toggle flips after each grant to that port.
- Granted write:
  - awready and wready are driven high for that port in the same cycle (both are asserted together).
  - At the edge, each byte lane i with wstrb[i]=1 is written to mem[awaddr[ADDR_WIDTH-1:WORD_LSB]]; unstrobed lanes keep their value.
  - bvalid rises the next cycle and holds until bready.
- Granted read:
  - arready is high for that port in the same cycle.
  - rvalid/rdata appear 1 cycle later (PIPELINE_OUTPUT=0) or 2 cycles later (PIPELINE_OUTPUT=1).
  - rdata holds stable until rready. The R register only updates on the read path.
- Non-granted ports see ready=0.
- Throughput: one access per cycle aggregate. A single port can complete at most one transaction per two cycles, because of the response gap.
- Collisions:
  - Write and read to the same word cannot occur in the same cycle (single grant).
  - A read granted the cycle after a write observes the new data.
- Address bits below WORD_LSB are ignored. Addresses are always in range.
- The response channel may be back-pressured indefinitely; the port stays blocked and other ports proceed.

Decomposition:
- Package axil_mp_ram_pkg:
  - AXI response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Function clog2 for WORD_LSB.
- Sub-module axil_rr_arbiter:
  - Parameter PORTS.
  - Inputs: req vector, advance.
  - Outputs: one-hot grant, grant_idx, valid.
  - Holds the pointer register.
- Top level holds the memory array, per-port B/R pending flags, the toggle vector and the R pipeline.

Test Plan:
- Reset, then single write: port 0 writes 0xDEADBEEF to 0x010 with wstrb=4'hF -> bvalid on cycle+1, bresp=00. Port 1 then reads 0x010 -> rdata=0xDEADBEEF after 1 cycle.
- Strobes: write 0x11223344 to 0x020, then 0xAABBCCDD with wstrb=4'b0101 -> read returns 0x11BB33DD.
- Contention: all 4 ports assert arvalid in the same cycle with pointer=0 -> arready granted to ports 0,1,2,3 in consecutive cycles. Re-asserting immediately yields the grant order 0,1,2,3 again.
- Backpressure: port 2 holds rready=0 for 10 cycles -> rvalid and rdata stable, arready[2]=0 throughout. Ports 0/1/3 continue to be granted.
- Same-port write and read pending together -> served alternately W, R, W. With PIPELINE_OUTPUT=1, read latency is exactly 2 cycles.
- Reset asserted while port 3 has bvalid=1 -> bvalid=0 the next cycle and no response afterwards. Memory still holds the data written before reset.
